// File: rtl/mbgd_ram_arbiter_if.sv
// Bundle of both requester ports plus the RAM macro pins around the MBGD RAM arbiter.
// Latency: none; this is only wiring. The arbiter uses the slave modport, requesters and RAM use master.
// Backpressure: requesters hold req until done; the RAM never stalls.
interface mbgd_ram_arbiter_if #(
  parameter int ADDR = 8,
  parameter int DATA = 8
);
  // port A (APB register-file path)
  logic            a_req;
  logic            a_rd;
  logic [ADDR-1:0] a_addr;
  logic [DATA-1:0] a_wdata;
  logic            a_gnt;
  logic            a_done;
  logic [DATA-1:0] a_rdata;
  // port B (MBGD compute engine)
  logic            b_req;
  logic            b_rd;
  logic [ADDR-1:0] b_addr;
  logic [DATA-1:0] b_wdata;
  logic            b_gnt;
  logic            b_done;
  logic [DATA-1:0] b_rdata;
  // RAM macro pins
  logic [ADDR-1:0] RAM_Addr;
  logic [DATA-1:0] RAM_dataIn;
  logic            RAM_CS;
  logic            RAM_RD;
  logic [DATA-1:0] RAM_dataOut;

  modport master (
    output a_req, a_rd, a_addr, a_wdata,
    input  a_gnt, a_done, a_rdata,
    output b_req, b_rd, b_addr, b_wdata,
    input  b_gnt, b_done, b_rdata,
    input  RAM_Addr, RAM_dataIn, RAM_CS, RAM_RD,
    output RAM_dataOut
  );

  modport slave (
    input  a_req, a_rd, a_addr, a_wdata,
    output a_gnt, a_done, a_rdata,
    input  b_req, b_rd, b_addr, b_wdata,
    output b_gnt, b_done, b_rdata,
    output RAM_Addr, RAM_dataIn, RAM_CS, RAM_RD,
    input  RAM_dataOut
  );
endinterface

// File: rtl/mbgd_ram_arbiter.sv
// Round-robin arbiter sharing the single-port MBGD RAM between port A (APB) and port B (engine).
// Latency: req seen in IDLE -> RAM_CS next cycle -> done two cycles after that; 3 cycles per access back-to-back.
// Backpressure: the losing port keeps req high and waits; nothing is queued inside the arbiter.
module mbgd_ram_arbiter #(
  parameter int ADDR = 8,
  parameter int DATA = 8
) (
  input  logic                 apb_pclk,
  input  logic                 resetn,
  mbgd_ram_arbiter_if.slave    bus,
  output logic                 busy,
  output logic [1:0]           state
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT  = 2'b01,
    ACCESS = 2'b10,
    DONE   = 2'b11
  } st_e;

  st_e             cur_st;
  st_e             nxt_st;
  // owner_b doubles as the round-robin pointer: it names the port being (or last) served.
  // Resetting it to B makes A the favoured port after reset.
  logic            owner_b;
  logic            load;
  logic            load_b;
  logic            rd_q;
  logic [ADDR-1:0] addr_q;
  logic [DATA-1:0] wdata_q;
  logic [DATA-1:0] a_rdata_q;
  logic [DATA-1:0] b_rdata_q;

  // next state, winner selection and state-decoded handshake outputs
  always_comb begin
    nxt_st      = cur_st;
    load        = 1'b0;
    load_b      = owner_b;
    bus.a_gnt   = 1'b0;
    bus.b_gnt   = 1'b0;
    bus.a_done  = 1'b0;
    bus.b_done  = 1'b0;
    bus.RAM_CS  = 1'b0;
    case (cur_st)
      IDLE: begin
        if (bus.a_req || bus.b_req) begin
          load   = 1'b1;
          // B wins if it is alone, or if both ask and A was served last
          load_b = bus.b_req && (!bus.a_req || !owner_b);
          nxt_st = GRANT;
        end
      end
      GRANT: begin
        bus.RAM_CS = 1'b1;
        nxt_st     = ACCESS;
      end
      ACCESS: begin
        nxt_st = DONE;
      end
      DONE: begin
        // the finishing port's own req is ignored here; only the other port can chain in
        load_b = !owner_b;
        load   = owner_b ? bus.a_req : bus.b_req;
        nxt_st = load ? GRANT : IDLE;
        bus.a_done = !owner_b;
        bus.b_done = owner_b;
      end
      default: nxt_st = IDLE;
    endcase
    if (cur_st != IDLE) begin
      bus.a_gnt = !owner_b;
      bus.b_gnt = owner_b;
    end
  end

  // state register
  always_ff @(posedge apb_pclk or negedge resetn) begin
    if (!resetn) cur_st <= IDLE;
    else         cur_st <= nxt_st;
  end

  // operand latch (also the RAM pin registers), pointer update and read-data capture
  always_ff @(posedge apb_pclk or negedge resetn) begin
    if (!resetn) begin
      owner_b   <= 1'b1;
      rd_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      if (load) begin
        owner_b <= load_b;
        rd_q    <= load_b ? bus.b_rd    : bus.a_rd;
        addr_q  <= load_b ? bus.b_addr  : bus.a_addr;
        wdata_q <= load_b ? bus.b_wdata : bus.a_wdata;
      end
      // RAM_dataOut is valid in the cycle after RAM_CS, which is ACCESS
      if (cur_st == ACCESS && rd_q) begin
        if (owner_b) b_rdata_q <= bus.RAM_dataOut;
        else         a_rdata_q <= bus.RAM_dataOut;
      end
    end
  end

  assign bus.RAM_Addr   = addr_q;
  assign bus.RAM_dataIn = wdata_q;
  assign bus.RAM_RD     = rd_q;
  assign bus.a_rdata    = a_rdata_q;
  assign bus.b_rdata    = b_rdata_q;
  assign busy           = (cur_st != IDLE);
  assign state          = cur_st;

endmodule

// File: tb/tb_mbgd_ram_arbiter.sv
// Bench for mbgd_ram_arbiter: directed and random accesses against a transaction-level model.
// The model keeps a shadow memory and a "last served" bit and predicts order, latency and read data.
// A behavioural RAM answers reads the cycle after RAM_CS.
module tb_mbgd_ram_arbiter;
  logic       clk = 1'b0;
  logic       resetn;
  logic       busy;
  logic [1:0] state;

  mbgd_ram_arbiter_if #(.ADDR(8), .DATA(8)) bus ();

  mbgd_ram_arbiter #(.ADDR(8), .DATA(8)) dut (
    .apb_pclk (clk),
    .resetn   (resetn),
    .bus      (bus),
    .busy     (busy),
    .state    (state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // monitor-owned observations
  int         cs_total = 0;
  int         a_done_total = 0;
  int         b_done_total = 0;
  int         both_gnt = 0;
  logic [7:0] last_cs_addr = '0;
  logic [7:0] last_cs_din = '0;
  logic       last_cs_rd = 1'b0;

  // reference model state
  logic [7:0] ref_mem [256];
  bit         last_b;
  logic [7:0] exp_a_rdata;
  logic [7:0] exp_b_rdata;

  // behavioural RAM: samples pins mid-cycle, acts on the rising edge
  initial begin : ram_model
    logic [7:0] ram [256];
    logic       s_cs, s_rd;
    logic [7:0] s_addr, s_din;
    for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'hA5;
    bus.RAM_dataOut = '0;
    forever begin
      @(negedge clk);
      s_cs = bus.RAM_CS; s_rd = bus.RAM_RD; s_addr = bus.RAM_Addr; s_din = bus.RAM_dataIn;
      @(posedge clk);
      if (s_cs) begin
        if (s_rd) bus.RAM_dataOut <= ram[s_addr];
        else      ram[s_addr] = s_din;
      end
    end
  end

  // pin monitor
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (bus.RAM_CS) begin
        cs_total++;
        last_cs_addr = bus.RAM_Addr;
        last_cs_din  = bus.RAM_dataIn;
        last_cs_rd   = bus.RAM_RD;
      end
      if (bus.a_gnt && bus.b_gnt) both_gnt++;
      if (bus.a_done) a_done_total++;
      if (bus.b_done) b_done_total++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input bit pb, input bit req, input bit rd,
                          input logic [7:0] addr, input logic [7:0] wd);
    if (pb) begin
      bus.b_req = req; bus.b_rd = rd; bus.b_addr = addr; bus.b_wdata = wd;
    end else begin
      bus.a_req = req; bus.a_rd = rd; bus.a_addr = addr; bus.a_wdata = wd;
    end
  endtask

  // model: apply one access to the shadow memory, return what a read would see
  function automatic logic [7:0] model_access(input bit rd, input logic [7:0] addr,
                                               input logic [7:0] wd);
    if (!rd) ref_mem[addr] = wd;
    return ref_mem[addr];
  endfunction

  // one access from a single port; operands are scrambled right after grant
  task automatic single(input bit pb, input bit rd, input logic [7:0] addr,
                        input logic [7:0] wd, input logic [7:0] scr_addr, input string tag);
    int cs0, ad0, bd0, dk;
    logic [7:0] rv;
    cs0 = cs_total; ad0 = a_done_total; bd0 = b_done_total; dk = 0;
    rv = model_access(rd, addr, wd);
    if (rd) begin
      if (pb) exp_b_rdata = rv; else exp_a_rdata = rv;
    end
    tick();
    set_port(pb, 1'b1, rd, addr, wd);
    for (int k = 1; k <= 10 && dk == 0; k++) begin
      @(negedge clk);
      if (k == 2) begin
        chk({tag, "_gnt"}, {31'd0, pb ? bus.b_gnt : bus.a_gnt}, 32'd1);
        chk({tag, "_gnt_other"}, {31'd0, pb ? bus.a_gnt : bus.b_gnt}, 32'd0);
        set_port(pb, 1'b1, ~rd, scr_addr, ~wd);
      end
      if (pb ? bus.b_done : bus.a_done) begin
        dk = k;
        chk({tag, "_rdata"}, {24'd0, pb ? bus.b_rdata : bus.a_rdata}, {24'd0, pb ? exp_b_rdata : exp_a_rdata});
      end
    end
    chk({tag, "_latency"}, dk, 4);
    tick();
    set_port(pb, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    chk({tag, "_cs_count"}, cs_total - cs0, 1);
    chk({tag, "_ram_addr"}, {24'd0, last_cs_addr}, {24'd0, addr});
    chk({tag, "_ram_rd"}, {31'd0, last_cs_rd}, {31'd0, rd});
    if (!rd) chk({tag, "_ram_din"}, {24'd0, last_cs_din}, {24'd0, wd});
    chk({tag, "_done_own"}, pb ? b_done_total - bd0 : a_done_total - ad0, 1);
    chk({tag, "_done_other"}, pb ? a_done_total - ad0 : b_done_total - bd0, 0);
    chk({tag, "_idle"}, {30'd0, state}, 32'd0);
    last_b = pb;
  endtask

  // both ports request in the same cycle
  task automatic pair(input bit ard, input logic [7:0] aad, input logic [7:0] awd,
                      input bit brd, input logic [7:0] bad, input logic [7:0] bwd, input string tag);
    bit fb, a_seen, b_seen;
    logic [7:0] ea, eb, rv;
    int cs0;
    fb = !last_b;
    ea = exp_a_rdata; eb = exp_b_rdata;
    if (fb) begin
      rv = model_access(brd, bad, bwd); if (brd) eb = rv;
      rv = model_access(ard, aad, awd); if (ard) ea = rv;
    end else begin
      rv = model_access(ard, aad, awd); if (ard) ea = rv;
      rv = model_access(brd, bad, bwd); if (brd) eb = rv;
    end
    cs0 = cs_total; a_seen = 0; b_seen = 0;
    tick();
    set_port(1'b0, 1'b1, ard, aad, awd);
    set_port(1'b1, 1'b1, brd, bad, bwd);
    for (int k = 1; k <= 12 && !(a_seen && b_seen); k++) begin
      bit drop_a, drop_b;
      drop_a = 0; drop_b = 0;
      @(negedge clk);
      if (k == 5) chk({tag, "_chain_grant"}, {30'd0, state}, 32'd1);
      if (bus.a_done) begin
        chk({tag, "_a_cycle"}, k, fb ? 7 : 4);
        chk({tag, "_a_rdata"}, {24'd0, bus.a_rdata}, {24'd0, ea});
        a_seen = 1; drop_a = 1;
      end
      if (bus.b_done) begin
        chk({tag, "_b_cycle"}, k, fb ? 4 : 7);
        chk({tag, "_b_rdata"}, {24'd0, bus.b_rdata}, {24'd0, eb});
        b_seen = 1; drop_b = 1;
      end
      if (drop_a || drop_b) begin
        tick();
        if (drop_a) set_port(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
        if (drop_b) set_port(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
      end
    end
    chk({tag, "_both_done"}, {30'd0, a_seen, b_seen}, 32'd3);
    repeat (2) @(negedge clk);
    chk({tag, "_cs_count"}, cs_total - cs0, 2);
    exp_a_rdata = ea; exp_b_rdata = eb;
    last_b = !fb;
  endtask

  initial begin : main
    int n, prev_k, bd0;
    bit exp_port, got_port;
    logic [7:0] rv;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'hA5;
    last_b = 1'b1; exp_a_rdata = '0; exp_b_rdata = '0;
    resetn = 1'b0;
    set_port(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    set_port(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    chk("rst_gnt", {30'd0, bus.a_gnt, bus.b_gnt}, 32'd0);
    chk("rst_done", {30'd0, bus.a_done, bus.b_done}, 32'd0);
    chk("rst_rdata", {16'd0, bus.a_rdata, bus.b_rdata}, 32'd0);
    chk("rst_ram", {14'd0, bus.RAM_Addr, bus.RAM_dataIn, bus.RAM_CS, bus.RAM_RD}, 32'd0);
    chk("rst_busy_state", {29'd0, busy, state}, 32'd0);
    tick();
    resetn = 1'b1;

    // directed accesses
    single(1'b0, 1'b0, 8'h14, 8'h5A, 8'h77, "a_wr14");
    single(1'b0, 1'b1, 8'h14, 8'h00, 8'h15, "a_rd14");
    single(1'b1, 1'b0, 8'h20, 8'h3C, 8'h30, "b_addr_hold");
    single(1'b1, 1'b1, 8'h20, 8'h00, 8'h30, "b_rd20");

    // both held high: A writes 0x40, B reads 0x40, seven accesses in total
    exp_port = !last_b; n = 0; prev_k = 0;
    tick();
    set_port(1'b0, 1'b1, 1'b0, 8'h40, 8'hC3);
    set_port(1'b1, 1'b1, 1'b1, 8'h40, 8'h00);
    for (int k = 1; k <= 40 && n < 7; k++) begin
      @(negedge clk);
      if (bus.a_done || bus.b_done) begin
        got_port = bus.b_done;
        chk("hold_order", {31'd0, got_port}, {31'd0, exp_port});
        chk("hold_spacing", k - prev_k, (n == 0) ? 4 : 3);
        if (got_port) begin
          rv = model_access(1'b1, 8'h40, 8'h00);
          exp_b_rdata = rv;
          chk("hold_b_rdata", {24'd0, bus.b_rdata}, {24'd0, exp_b_rdata});
        end else begin
          rv = model_access(1'b0, 8'h40, 8'hC3);
        end
        last_b = got_port;
        exp_port = !exp_port; prev_k = k; n++;
        if (n == 6) begin
          tick();
          set_port(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
          set_port(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
        end
      end
    end
    chk("hold_count", n, 7);
    repeat (2) @(negedge clk);
    chk("hold_idle", {31'd0, busy}, 32'd0);
    chk("hold_excl", both_gnt, 0);

    // reset during ACCESS of a B read
    bd0 = b_done_total;
    tick();
    set_port(1'b1, 1'b1, 1'b1, 8'h14, 8'h00);
    repeat (3) @(negedge clk);
    chk("mid_access_state", {30'd0, state}, 32'd2);
    #1 resetn = 1'b0;
    #1;
    chk("arst_gnt", {30'd0, bus.a_gnt, bus.b_gnt}, 32'd0);
    chk("arst_cs_rd", {30'd0, bus.RAM_CS, bus.RAM_RD}, 32'd0);
    chk("arst_ram_bus", {16'd0, bus.RAM_Addr, bus.RAM_dataIn}, 32'd0);
    chk("arst_rdata", {16'd0, bus.a_rdata, bus.b_rdata}, 32'd0);
    chk("arst_busy_state", {29'd0, busy, state}, 32'd0);
    set_port(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    chk("arst_no_b_done", b_done_total - bd0, 0);
    tick();
    resetn = 1'b1;
    last_b = 1'b1; exp_a_rdata = '0; exp_b_rdata = '0;

    // simultaneous request after reset: A first, B chained straight from DONE
    pair(1'b0, 8'h14, 8'h11, 1'b1, 8'h14, 8'h00, "pair_rst");
    pair(1'b1, 8'h14, 8'h00, 1'b0, 8'h55, 8'h99, "pair_2");

    // random traffic over a small address window so reads hit earlier writes
    for (int i = 0; i < 16; i++) begin
      bit pb, rd;
      logic [7:0] ad, wd, sa;
      pb = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      ad = 8'h80 + 8'($urandom_range(0, 7));
      wd = 8'($urandom);
      sa = 8'($urandom);
      single(pb, rd, ad, wd, sa, "rnd_single");
    end
    for (int i = 0; i < 6; i++) begin
      bit ar, br;
      logic [7:0] aa, ba, aw, bw;
      ar = 1'($urandom_range(0, 1));
      br = 1'($urandom_range(0, 1));
      aa = 8'h80 + 8'($urandom_range(0, 3));
      ba = 8'h80 + 8'($urandom_range(0, 3));
      aw = 8'($urandom);
      bw = 8'($urandom);
      pair(ar, aa, aw, br, ba, bw, "rnd_pair");
    end
    chk("final_excl", both_gnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
